seg7_debug_display: RTL

Board-level debug front end that sits directly downstream of the pipelined datapath's debug port. It drives the `cn3` select bus into the datapath from two debounced pushbuttons. It consumes the returned 32-bit `disdata` word and shows it as eight hex digits on a time-multiplexed, common-anode seven-segment display. Snapshotting, debouncing and scanning are fully synchronous to the CPU clock.

---
 rtl/seg7_debug_display_if.sv | 20 ++
 rtl/seg7_debug_display.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg7_debug_display_if.sv
// Debug front-end bundle: raw buttons and the returned debug word in, cn3 select and display drive out.
// The slave modport is the display block; the master modport is the board/datapath side.
interface seg7_debug_display_if;
   logic        btn_sel;
   logic        btn_reg;
   logic [31:0] disdata;
   logic [8:0]  cn3;
   logic [7:0]  an;
   logic [6:0]  seg;

   modport master (
      output btn_sel, btn_reg, disdata,
      input  cn3, an, seg
   );

   modport slave (
      input  btn_sel, btn_reg, disdata,
      output cn3, an, seg
   );
endinterface

// File: rtl/seg7_debug_display.sv
// Debounced buttons step the cn3 debug select; the returned word is snapshotted per frame and scanned onto 8 hex digits.
// Button to cn3 takes DEBOUNCE_CYCLES+3 edges, an/seg lag the digit index by one edge; there is no backpressure.
module seg7_debug_display #(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SEL_MAX         = 11
) (
   input logic clk,
   input logic reset,
   seg7_debug_display_if.slave dbg
);
   localparam int PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DebW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      SelLast = 4'(SEL_MAX);

   // Bit 0 is the view-select button, bit 1 the register-index button.
   logic [1:0]           btnRaw;
   logic [1:0]           syncA;
   logic [1:0]           syncB;
   logic [1:0]           level;
   logic [1:0]           armed;
   logic [1:0]           pulse;
   logic [1:0]           warm;
   logic [1:0][DebW-1:0] debCnt;

   logic [3:0]  viewSel;
   logic [4:0]  regIdx;

   logic [PreW-1:0] preCnt;
   logic [2:0]      digit;
   logic [31:0]     snap;
   logic [3:0]      nibble;

   assign btnRaw = {dbg.btn_reg, dbg.btn_sel};

   // A button only arms once its synchronized and debounced levels have both been seen low
   // after reset, so a press held through reset never counts until it is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncA  <= '0;
         syncB  <= '0;
         level  <= '0;
         armed  <= '0;
         pulse  <= '0;
         warm   <= '0;
         debCnt <= '0;
      end else begin
         syncA <= btnRaw;
         syncB <= syncA;
         warm  <= {warm[0], 1'b1};
         for (int i = 0; i < 2; i++) begin
            pulse[i] <= 1'b0;
            if (syncB[i] == level[i]) begin
               debCnt[i] <= '0;
               if (warm[1] && !level[i]) begin
                  armed[i] <= 1'b1;
               end
            end else if (debCnt[i] == DebLast) begin
               debCnt[i] <= '0;
               level[i]  <= syncB[i];
               pulse[i]  <= syncB[i] & armed[i];
            end else begin
               debCnt[i] <= debCnt[i] + DebW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         viewSel <= '0;
         regIdx  <= '0;
      end else begin
         if (pulse[0]) begin
            viewSel <= (viewSel >= SelLast) ? 4'd0 : viewSel + 4'd1;
         end
         if (pulse[1]) begin
            regIdx <= regIdx + 5'd1;
         end
      end
   end

   assign dbg.cn3 = {viewSel, regIdx};

   // The snapshot reloads only as digit 7 hands over to digit 0, so one frame shows one word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preCnt <= '0;
         digit  <= '0;
         snap   <= '0;
      end else if (preCnt == PreLast) begin
         preCnt <= '0;
         digit  <= digit + 3'd1;
         if (digit == 3'd7) begin
            snap <= dbg.disdata;
         end
      end else begin
         preCnt <= preCnt + PreW'(1);
      end
   end

   assign nibble = snap[{digit, 2'b00} +: 4];

   function automatic logic [6:0] hexSeg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dbg.an  <= 8'hFF;
         dbg.seg <= 7'h7F;
      end else begin
         dbg.an  <= ~(8'd1 << digit);
         dbg.seg <= hexSeg(nibble);
      end
   end
endmodule
